data_memory_ctrl: RTL and testbench

- 64-bit doubleword data memory with a multi-cycle access controller.
- Sits directly downstream of the ALU: the ALU result drives Address for LDUR/STUR, and register-file BusB drives WriteData.
- Models a fixed-latency memory. Busy stalls the PC, and Done marks the cycle in which ReadData and the write commit are final.

---
 rtl/data_memory_ctrl.sv | 128 ++++++++++++
 tb/tb_data_memory_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// 64-bit doubleword data memory behind a fixed-latency IDLE/WAIT/DONE access controller.
// Optional build macro DMEM_ALIGN_CHECK_EN faults on addresses that are not doubleword aligned.
module data_memory_ctrl #(
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] Address,
    input  logic [63:0] WriteData,
    output logic [63:0] ReadData,
    output logic        Busy,
    output logic        Done,
    output logic        Fault
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e         r_state, w_state_d;
    logic [3:0]     r_cnt, w_cnt_d;
    logic           r_is_write, w_is_write_d;
    logic [AW-1:0]  r_idx, w_idx_d;
    logic [63:0]    r_wdata, w_wdata_d;
    logic [63:0]    r_rdata, w_rdata_d;
    logic           r_busy, w_busy_d;
    logic           r_done, w_done_d;
    logic           r_fault, w_fault_d;
    logic           w_mem_we;
    logic           w_bad_addr;
    logic [63:0]    r_mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_bad_addr = (|Address[63:AW+3]) || (|Address[2:0]);
`else
    // Byte offset within the doubleword is deliberately dropped in this build.
    logic w_unused_lsb;
    assign w_unused_lsb = ^Address[2:0];
    assign w_bad_addr   = |Address[63:AW+3];
`endif

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_is_write_d = r_is_write;
        w_idx_d      = r_idx;
        w_wdata_d    = r_wdata;
        w_rdata_d    = r_rdata;
        w_busy_d     = 1'b0;
        w_done_d     = 1'b0;
        w_fault_d    = 1'b0;
        w_mem_we     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (MemRead || MemWrite) begin
                    if ((MemRead && MemWrite) || w_bad_addr) begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                        w_fault_d = 1'b1;
                    end else begin
                        w_state_d    = StWait;
                        w_cnt_d      = 4'(LATENCY);
                        w_is_write_d = MemWrite;
                        w_idx_d      = Address[AW+2:3];
                        w_wdata_d    = WriteData;
                        w_busy_d     = 1'b1;
                    end
                end
            end
            StWait: begin
                if (r_cnt == 4'd1) begin
                    w_state_d = StDone;
                    w_cnt_d   = '0;
                    w_done_d  = 1'b1;
                    if (r_is_write) begin
                        w_mem_we = 1'b1;
                    end else begin
                        w_rdata_d = r_mem[r_idx];
                    end
                end else begin
                    w_cnt_d  = r_cnt - 4'd1;
                    w_busy_d = 1'b1;
                end
            end
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_is_write <= 1'b0;
            r_idx      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_is_write <= w_is_write_d;
            r_idx      <= w_idx_d;
            r_wdata    <= w_wdata_d;
            r_rdata    <= w_rdata_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
            r_fault    <= w_fault_d;
        end
    end

    // Array is never cleared; reset only blocks a commit that lands on the same edge.
    always_ff @(posedge Clk) begin
        if (!Reset && w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ReadData = r_rdata;
    assign Busy     = r_busy;
    assign Done     = r_done;
    assign Fault    = r_fault;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against an array-based reference model.
module tb_data_memory_ctrl;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned AW      = $clog2(DEPTH);

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead;
    logic        MemWrite;
    logic [63:0] Address;
    logic [63:0] WriteData;
    logic [63:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        Fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_mem [DEPTH];
    logic [63:0] m_rdata;

    data_memory_ctrl #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Busy      (Busy),
        .Done      (Done),
        .Fault     (Fault)
    );

    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_fault(input bit rd, input bit wr, input logic [63:0] a);
        bit f;
        f = (rd && wr) || ((a >> (AW + 3)) != 64'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        f = f || (a[2:0] != 3'd0);
`endif
        return f;
    endfunction

    task automatic drive_junk();
        MemRead   = 1'($urandom);
        MemWrite  = 1'($urandom);
        Address   = {$urandom, $urandom};
        WriteData = {$urandom, $urandom};
    endtask

    task automatic drive_idle();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        WriteData = '0;
    endtask

    // Called just after a negedge with the DUT idle; returns one negedge after the DONE cycle.
    task automatic access(input bit rd, input bit wr, input logic [63:0] a, input logic [63:0] d);
        bit f;
        int idx;
        int want;
        int n;
        bit seen;
        f    = exp_fault(rd, wr, a);
        idx  = int'((a >> 3) % 64'(DEPTH));
        want = f ? 1 : int'(LATENCY) + 1;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = a;
        WriteData = d;
        @(posedge Clk);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge Clk);
            n++;
            check_val("busy", 64'(Busy), 64'(!f && n <= int'(LATENCY)));
            seen = Done;
            drive_junk();
        end
        check_val("done_cycle", 64'(n), 64'(want));
        check_val("fault", 64'(Fault), 64'(f));
        if (!f && wr) m_mem[idx] = d;
        if (!f && rd) m_rdata = m_mem[idx];
        check_val("rdata", ReadData, m_rdata);
        @(posedge Clk);
        @(negedge Clk);
        check_val("done_pulse", 64'(Done), 64'd0);
        check_val("idle_busy", 64'(Busy), 64'd0);
        drive_idle();
    endtask

    initial begin
        int r;
        int r2;
        logic [63:0] a;
        logic [63:0] d;

        Reset = 1'b1;
        drive_idle();
        m_rdata = '0;
        repeat (3) @(negedge Clk);
        check_val("rst_rdata", ReadData, 64'd0);
        check_val("rst_busy", 64'(Busy), 64'd0);
        check_val("rst_done", 64'(Done), 64'd0);
        check_val("rst_fault", 64'(Fault), 64'd0);
        Reset = 1'b0;

        repeat (3) begin
            @(negedge Clk);
            check_val("idle_pulses", {61'd0, Busy, Done, Fault}, 64'd0);
        end

        for (int i = 0; i < int'(DEPTH); i++) begin
            access(1'b0, 1'b1, 64'(i) * 64'd8, {$urandom, $urandom});
        end

        access(1'b0, 1'b1, 64'h10, 64'hDEAD_BEEF_CAFE_F00D);
        access(1'b1, 1'b0, 64'h10, 64'd0);
        check_val("wr_rd_10", ReadData, 64'hDEAD_BEEF_CAFE_F00D);
        access(1'b1, 1'b0, 64'h200, 64'd0);
        access(1'b1, 1'b1, 64'h8, 64'h5555);
        access(1'b1, 1'b0, 64'h8, 64'd0);

        // Reset during the first wait cycle of a write must drop the write.
        MemWrite  = 1'b1;
        Address   = 64'h18;
        WriteData = 64'h1234;
        @(posedge Clk);
        @(negedge Clk);
        check_val("midwr_busy", 64'(Busy), 64'd1);
        Reset = 1'b1;
        drive_idle();
        @(posedge Clk);
        @(negedge Clk);
        m_rdata = '0;
        check_val("midwr_outs", {61'd0, Busy, Done, Fault}, 64'd0);
        check_val("midwr_rdata", ReadData, 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        access(1'b1, 1'b0, 64'h18, 64'd0);

        access(1'b1, 1'b0, 64'h0, 64'd0);
        access(1'b1, 1'b0, 64'h0, 64'd0);
        access(1'b1, 1'b0, 64'h13, 64'd0);

        for (int k = 0; k < 300; k++) begin
            r  = int'($urandom_range(0, 99));
            r2 = int'($urandom_range(0, 9));
            a  = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
            if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(1, 7));
            if (r < 12) a = a | (64'd1 << $urandom_range(AW + 3, 63));
            d = {$urandom, $urandom};
            if (r2 == 0) access(1'b1, 1'b1, a, d);
            else if (r2 < 6) access(1'b1, 1'b0, a, d);
            else access(1'b0, 1'b1, a, d);
            if ($urandom_range(0, 4) == 0) begin
                @(negedge Clk);
                check_val("gap_idle", {61'd0, Busy, Done, Fault}, 64'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
